// File: rtl/shifter_pkg.sv
// Shared types for the sequential shifter: operation codes, FSM states and a
// helper that sizes the per-cycle shift-amount field.
package shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROL = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } shift_state_t;

  // Bits needed to hold a per-cycle shift amount in 0..step.
  function automatic int step_width(input int step);
    return (step < 1) ? 1 : $clog2(step + 1);
  endfunction

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single step: shifts acc_i by k_i (0..STEP) bits using op_i.
// ROL is only built when SEQ_SHIFTER_ROTATE_EN is defined; otherwise op=11 acts as SLL.
module shift_step
  import shifter_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 1
) (
  input  logic [N-1:0]                 acc_i,
  input  shift_op_t                    op_i,
  input  logic [step_width(STEP)-1:0]  k_i,
  output logic [N-1:0]                 acc_o
);

`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [2*N-1:0] rot_w;
`endif

  always_comb begin
    acc_o = acc_i << k_i;
`ifdef SEQ_SHIFTER_ROTATE_EN
    rot_w = {acc_i, acc_i} << k_i;
`endif
    case (op_i)
      OP_SRL: acc_o = acc_i >> k_i;
      // Arithmetic shift keeps the MSB, so repeated steps replicate the original sign.
      OP_SRA: acc_o = $unsigned($signed(acc_i) >>> k_i);
`ifdef SEQ_SHIFTER_ROTATE_EN
      OP_ROL: acc_o = rot_w[2*N-1:N];
`endif
      default: acc_o = acc_i << k_i;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: start/done handshake, up to STEP bits per cycle.
// Optional rotate support via `define SEQ_SHIFTER_ROTATE_EN.
//
// Handshake: start is accepted on a rising edge only while the FSM is IDLE
// (busy=0, done=0); busy is high through SHIFT, done pulses for one cycle with
// dout valid, and dout holds until the next completed request.
module seq_shifter
  import shifter_pkg::*;
#(
  parameter int N    = 32,
  parameter int STEP = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic [N-1:0]          din,
  input  logic [$clog2(N)-1:0]  shamt,
  output logic                  busy,
  output logic                  done,
  output logic [N-1:0]          dout,
  output shift_state_t          dbg_state
);

  localparam int SW = $clog2(N);
  localparam int KW = step_width(STEP);
  localparam logic [SW-1:0] STEP_W = SW'(STEP);

  shift_state_t   state_q, state_d;
  shift_op_t      op_q, op_d;
  logic [N-1:0]   acc_q, acc_d;
  logic [SW-1:0]  rem_q, rem_d;
  logic [N-1:0]   dout_q, dout_d;
  logic [KW-1:0]  k;
  logic [N-1:0]   acc_shifted;

  always_comb begin
    k = (rem_q > STEP_W) ? KW'(STEP) : rem_q[KW-1:0];
  end

  shift_step #(
    .N    (N),
    .STEP (STEP)
  ) u_step (
    .acc_i (acc_q),
    .op_i  (op_q),
    .k_i   (k),
    .acc_o (acc_shifted)
  );

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = din;
          op_d    = shift_op_t'(op);
          rem_d   = shamt;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (rem_q != '0) begin
          acc_d = acc_shifted;
          rem_d = rem_q - SW'(k);
        end else begin
          dout_d  = acc_q;
          state_d = S_DONE;
        end
      end
      // Any start arriving during DONE is dropped; the FSM always returns to IDLE.
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      op_q    <= OP_SLL;
      acc_q   <= '0;
      rem_q   <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      dout_q  <= dout_d;
    end
  end

  assign busy      = (state_q == S_SHIFT);
  assign done      = (state_q == S_DONE);
  assign dout      = dout_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter: a STEP=1 and a STEP=4 instance share stimulus;
// expected results and done times come from a plain arithmetic model.
module tb_seq_shifter;
  import shifter_pkg::*;

  localparam int N  = 32;
  localparam int SW = 5;

  logic           clk = 1'b0;
  logic           reset;
  logic           start, start4;
  logic [1:0]     op;
  logic [N-1:0]   din;
  logic [SW-1:0]  shamt;
  logic           busy1, done1, busy4, done4;
  logic [N-1:0]   dout1, dout4;
  shift_state_t   st1, st4;

  typedef struct {
    logic [N-1:0] val;
    int           due;
  } exp_t;

  exp_t         exp1_q[$];
  exp_t         exp4_q[$];
  logic [N-1:0] last1, last4;
  int           cycle = 0;
  int           tests = 0;
  int           fails = 0;

  seq_shifter #(.N(N), .STEP(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start), .op(op), .din(din), .shamt(shamt),
    .busy(busy1), .done(done1), .dout(dout1), .dbg_state(st1)
  );

  seq_shifter #(.N(N), .STEP(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .op(op), .din(din), .shamt(shamt),
    .busy(busy4), .done(done4), .dout(dout4), .dbg_state(st4)
  );

  // Clock and cycle index (cycle == number of rising edges seen so far).
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // Reference model: the single-step shift by sh, from the operation definitions.
  function automatic logic [N-1:0] model(input logic [1:0] o, input logic [N-1:0] d, input int sh);
    case (o)
      2'b01: return d >> sh;
      2'b10: return $signed(d) >>> sh;
`ifdef SEQ_SHIFTER_ROTATE_EN
      2'b11: return (sh == 0) ? d : ((d << sh) | (d >> (N - sh)));
`endif
      default: return d << sh;
    endcase
  endfunction

  task automatic wait_idle();
    int  n;
    bit  ok;
    n  = 0;
    ok = 0;
    while (!ok && n < 300) begin
      @(posedge clk); #1;
      n++;
      ok = !busy1 && !done1 && !busy4 && !done4 &&
           exp1_q.size() == 0 && exp4_q.size() == 0;
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL idle_timeout: pending1=%0d pending4=%0d after %0d cycles",
               exp1_q.size(), exp4_q.size(), n);
      exp1_q.delete();
      exp4_q.delete();
    end
  endtask

  // Driver: waits for IDLE, presents one request, records expectations, returns after accept.
  task automatic issue(input logic [1:0] o, input logic [N-1:0] d, input int sh,
                       input logic [N-1:0] e);
    exp_t x;
    wait_idle();
    op     = o;
    din    = d;
    shamt  = SW'(sh);
    start  = 1'b1;
    start4 = 1'b1;
    x.val = e;
    x.due = cycle + 1 + sh + 1;
    exp1_q.push_back(x);
    x.due = cycle + 1 + (sh + 3) / 4 + 1;
    exp4_q.push_back(x);
    @(posedge clk); #1;
    start  = 1'b0;
    start4 = 1'b0;
    op     = 2'($urandom);
    din    = $urandom;
    shamt  = SW'($urandom);
  endtask

  task automatic issue_rand();
    logic [1:0]   o;
    logic [N-1:0] d;
    int           sh;
    o  = 2'($urandom_range(0, 3));
    d  = $urandom;
    sh = $urandom_range(0, N - 1);
    issue(o, d, sh, model(o, d, sh));
  endtask

  // Monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      exp1_q.delete();
      exp4_q.delete();
      last1 = '0;
      last4 = '0;
    end else begin
      if (done1) begin
        if (exp1_q.size() == 0) begin
          check("done1_unexpected", 64'(done1), 64'(0));
        end else begin
          e = exp1_q.pop_front();
          check("dout1", 64'(dout1), 64'(e.val));
          check("done1_cycle", 64'(cycle), 64'(e.due));
          check("busy1_at_done", 64'(busy1), 64'(0));
        end
        last1 = dout1;
      end else if (!busy1) begin
        check("dout1_hold", 64'(dout1), 64'(last1));
      end
      if (done4) begin
        if (exp4_q.size() == 0) begin
          check("done4_unexpected", 64'(done4), 64'(0));
        end else begin
          e = exp4_q.pop_front();
          check("dout4", 64'(dout4), 64'(e.val));
          check("done4_cycle", 64'(cycle), 64'(e.due));
          check("busy4_at_done", 64'(busy4), 64'(0));
        end
        last4 = dout4;
      end else if (!busy4) begin
        check("dout4_hold", 64'(dout4), 64'(last4));
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset  = 1'b1;
    start  = 1'b0;
    start4 = 1'b0;
    op     = '0;
    din    = '0;
    shamt  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy1", 64'(busy1), 64'(0));
    check("rst_done1", 64'(done1), 64'(0));
    check("rst_dout1", 64'(dout1), 64'(0));
    check("rst_state1", 64'(st1), 64'(S_IDLE));
    check("rst_dout4", 64'(dout4), 64'(0));
    reset = 1'b0;

    // Directed cases.
    issue(2'b00, 32'h13579BDF, 2, 32'h4D5E6F7C);
    issue(2'b01, 32'hF0000000, 4, 32'h0F000000);
    issue(2'b10, 32'hF0000000, 4, 32'hFF000000);
    issue(2'b00, 32'hFFFFFFFF, 0, 32'hFFFFFFFF);
`ifdef SEQ_SHIFTER_ROTATE_EN
    issue(2'b11, 32'h80000001, 1, 32'h00000003);
`else
    issue(2'b11, 32'h80000001, 1, 32'h00000002);
`endif

    // Long shift with a start pulse mid-op and another during the DONE cycle.
    issue(2'b00, 32'h00000001, 31, 32'h80000000);
    repeat (5) @(posedge clk);
    #1;
    din = 32'h5; shamt = 5'd3; op = 2'b01;
    start = 1'b1; start4 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start4 = 1'b0;
    n = 0;
    while (!done1 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("done1_seen_long", 64'(done1), 64'(1));
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("start_in_done_ignored", 64'(busy1), 64'(0));

    // Reset in the middle of a shamt=20 SLL.
    issue(2'b00, 32'h0000ABCD, 20, 32'h0);
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy1", 64'(busy1), 64'(0));
    check("midrst_done1", 64'(done1), 64'(0));
    check("midrst_dout1", 64'(dout1), 64'(0));
    check("midrst_busy4", 64'(busy4), 64'(0));
    check("midrst_dout4", 64'(dout4), 64'(0));
    issue(2'b00, 32'h13579BDF, 2, 32'h4D5E6F7C);

    // Randomized requests.
    for (int i = 0; i < 60; i++) issue_rand();
    issue(2'b10, 32'h7FFFFFFF, 31, 32'h00000000);
    issue(2'b10, 32'h80000000, 31, 32'hFFFFFFFF);

    wait_idle();
    repeat (3) @(posedge clk);
    #1;
    check("queue1_drained", 64'(exp1_q.size()), 64'(0));
    check("queue4_drained", 64'(exp4_q.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
